// File: rtl/ni_inject_fifo_if.sv
// Flit handshake bundle between the source, the injection FIFO and the router port.
// slave is the FIFO's view; master is the surrounding environment's view.
interface ni_inject_fifo_if;
    logic [19:0] in_data;
    logic        in_valid;
    logic        src_en;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_head;
    logic        out_tail;

    modport slave (
        input  in_data, in_valid, out_ready,
        output src_en, out_data, out_valid, out_head, out_tail
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  src_en, out_data, out_valid, out_head, out_tail
    );
endinterface

// File: rtl/ni_inject_fifo.sv
// Injection FIFO: throttles a flit source via src_en, buffers flits and hands them
// to the router with head/tail tagging by position in a fixed-length packet.
module ni_inject_fifo #(
    parameter int DEPTH   = 32,
    parameter int PKT_LEN = 30,
    parameter int SKID    = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    ni_inject_fifo_if.slave            bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 pkt_cnt,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(PKT_LEN);

    logic [19:0]   mem [DEPTH];
    logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
    logic [FW-1:0] fidx_q, fidx_d;
    logic [7:0]    pkt_cnt_q, pkt_cnt_d;
    logic          ovf_q, ovf_d;
    logic          src_en_q, src_en_d;
    logic          empty, full, rd, wr, last_flit;
    logic [AW:0]   lvl_nxt;
    logic [AW+1:0] free_nxt;

    assign empty     = (wp_q == rp_q);
    assign full      = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign rd        = !empty && bus.out_ready;
    // A read in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr        = bus.in_valid && (!full || rd);
    assign last_flit = (fidx_q == FW'(PKT_LEN - 1));

    always_comb begin
        wp_d      = wr ? wp_q + 1'b1 : wp_q;
        rp_d      = rd ? rp_q + 1'b1 : rp_q;
        fidx_d    = fidx_q;
        pkt_cnt_d = pkt_cnt_q;
        ovf_d     = ovf_q || (bus.in_valid && full && !rd);
        if (rd) begin
            fidx_d = last_flit ? '0 : fidx_q + 1'b1;
            if (last_flit) pkt_cnt_d = pkt_cnt_q + 8'd1;
        end
        lvl_nxt  = wp_d - rp_d;
        free_nxt = (AW+2)'(DEPTH) - {1'b0, lvl_nxt};
        src_en_d = (free_nxt >= (AW+2)'(SKID));
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wp_q      <= '0;
            rp_q      <= '0;
            fidx_q    <= '0;
            pkt_cnt_q <= '0;
            ovf_q     <= 1'b0;
            src_en_q  <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            fidx_q    <= fidx_d;
            pkt_cnt_q <= pkt_cnt_d;
            ovf_q     <= ovf_d;
            src_en_q  <= src_en_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr) mem[wp_q[AW-1:0]] <= bus.in_data;
    end

    assign bus.src_en    = src_en_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem[rp_q[AW-1:0]];
    assign bus.out_head  = !empty && (fidx_q == '0);
    assign bus.out_tail  = !empty && last_flit;
    assign level         = wp_q - rp_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign overflow      = ovf_q;
endmodule
